// File: rtl/addsub_range_acc.sv
// ----------------------------------------------------------------------------
// addsub_range_acc
//   Signed add/subtract accumulator that keeps its value within 0..RANGE-1.
//   Each accepted command forms val +/- mag in a signed INT_W accumulator.
//   That raw sum is then range-fixed in one of two ways:
//     - wrap mode (mode=0): add or subtract RANGE once per cycle until the
//       sum is in range. This takes several cycles.
//     - saturate mode (mode=1): clamp to 0..RANGE-1 in a single cycle.
//
// Optional build macro:
//   ADDSUB_WRAP_COUNT_EN - adds the wrap_cnt output. It is a signed 8-bit
//                          count of wrap-mode reductions: +1 for each RANGE
//                          subtracted, -1 for each RANGE added.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   command valid; taken only while in_ready=1
//   mag        in   [MAG_W-1:0] unsigned command magnitude
//   dir        in   0 = add, 1 = subtract
//   mode       in   0 = wrap, 1 = saturate (latched at acceptance)
//   in_ready   out  idle and able to accept a command
//   val        out  [VAL_W-1:0] bounded accumulated value
//   val_valid  out  one-cycle pulse when val updates
//   range_hit  out  pulses with val_valid if any wrap/clamp occurred
//   int_watch  out  [INT_W-1:0] signed raw sum of last accepted command
//   wrap_cnt   out  [7:0] signed wrap counter (ADDSUB_WRAP_COUNT_EN only)
// ----------------------------------------------------------------------------
module addsub_range_acc #(
  parameter int MAG_W = 10,
  parameter int VAL_W = 7,
  parameter int RANGE = 100,
  parameter int INT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [MAG_W-1:0]   mag,
  input  logic               dir,
  input  logic               mode,
  output logic               in_ready,
  output logic [VAL_W-1:0]   val,
  output logic               val_valid,
  output logic               range_hit,
  output logic [INT_W-1:0]   int_watch
`ifdef ADDSUB_WRAP_COUNT_EN
  ,
  output logic signed [7:0]  wrap_cnt
`endif
);

  typedef enum logic {IDLE, FIX} state_t;

  localparam logic signed [INT_W-1:0] RANGE_S = INT_W'(RANGE);
  localparam logic [VAL_W-1:0]        VAL_MAX = VAL_W'(RANGE - 1);

  state_t                   state_reg, state_next;
  logic signed [INT_W-1:0]  acc_reg, acc_next;
  logic [VAL_W-1:0]         val_reg, val_next;
  logic [INT_W-1:0]         int_watch_reg, int_watch_next;
  logic                     mode_reg, mode_next;
  logic                     hit_reg, hit_next;
  logic                     val_valid_reg, val_valid_next;
  logic                     range_hit_reg, range_hit_next;
`ifdef ADDSUB_WRAP_COUNT_EN
  logic signed [7:0]        wrap_cnt_reg, wrap_cnt_next;
`endif

  // val is never negative, so it is zero-extended into the signed domain.
  logic signed [INT_W-1:0]  val_ext, mag_ext, sum;
  logic                     acc_neg, acc_over;

  assign val_ext = signed'({{(INT_W-VAL_W){1'b0}}, val_reg});
  assign mag_ext = signed'({{(INT_W-MAG_W){1'b0}}, mag});
  assign sum     = dir ? (val_ext - mag_ext) : (val_ext + mag_ext);

  assign acc_neg  = acc_reg[INT_W-1];
  assign acc_over = !acc_neg && (acc_reg >= RANGE_S);

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    val_next       = val_reg;
    int_watch_next = int_watch_reg;
    mode_next      = mode_reg;
    hit_next       = hit_reg;
    val_valid_next = 1'b0;
    range_hit_next = 1'b0;
`ifdef ADDSUB_WRAP_COUNT_EN
    wrap_cnt_next  = wrap_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (en) begin
          acc_next       = sum;
          int_watch_next = sum;
          mode_next      = mode;
          hit_next       = 1'b0;
          state_next     = FIX;
        end
      end
      FIX: begin
        if (mode_reg) begin
          // Saturate: one cycle, clamp to the range limits.
          if (acc_neg) begin
            val_next = '0;
          end else if (acc_over) begin
            val_next = VAL_MAX;
          end else begin
            val_next = acc_reg[VAL_W-1:0];
          end
          range_hit_next = acc_neg | acc_over;
          val_valid_next = 1'b1;
          state_next     = IDLE;
        end else if (acc_over) begin
          // Wrap: one RANGE correction per cycle until in range.
          acc_next = acc_reg - RANGE_S;
          hit_next = 1'b1;
`ifdef ADDSUB_WRAP_COUNT_EN
          wrap_cnt_next = wrap_cnt_reg + 8'sd1;
`endif
        end else if (acc_neg) begin
          acc_next = acc_reg + RANGE_S;
          hit_next = 1'b1;
`ifdef ADDSUB_WRAP_COUNT_EN
          wrap_cnt_next = wrap_cnt_reg - 8'sd1;
`endif
        end else begin
          val_next       = acc_reg[VAL_W-1:0];
          val_valid_next = 1'b1;
          range_hit_next = hit_reg;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      val_reg       <= '0;
      int_watch_reg <= '0;
      mode_reg      <= 1'b0;
      hit_reg       <= 1'b0;
      val_valid_reg <= 1'b0;
      range_hit_reg <= 1'b0;
`ifdef ADDSUB_WRAP_COUNT_EN
      wrap_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      val_reg       <= val_next;
      int_watch_reg <= int_watch_next;
      mode_reg      <= mode_next;
      hit_reg       <= hit_next;
      val_valid_reg <= val_valid_next;
      range_hit_reg <= range_hit_next;
`ifdef ADDSUB_WRAP_COUNT_EN
      wrap_cnt_reg  <= wrap_cnt_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign val       = val_reg;
  assign val_valid = val_valid_reg;
  assign range_hit = range_hit_reg;
  assign int_watch = int_watch_reg;
`ifdef ADDSUB_WRAP_COUNT_EN
  assign wrap_cnt  = wrap_cnt_reg;
`endif

endmodule

// File: tb/tb_addsub_range_acc.sv
// ----------------------------------------------------------------------------
// tb_addsub_range_acc
//   Self-checking bench for addsub_range_acc (default parameters).
//   A behavioural model predicts every output cycle by cycle. It works from
//   the arithmetic result and the latency of each command. Directed commands
//   pin the model with hand-computed values. Randomized commands, including
//   back-to-back streams, then exercise the rest.
// ----------------------------------------------------------------------------
module tb_addsub_range_acc;

  localparam int MAG_W = 10;
  localparam int VAL_W = 7;
  localparam int RANGE = 100;
  localparam int INT_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic [MAG_W-1:0] mag = '0;
  logic             dir = 1'b0;
  logic             mode = 1'b0;
  logic             in_ready;
  logic [VAL_W-1:0] val;
  logic             val_valid;
  logic             range_hit;
  logic [INT_W-1:0] int_watch;
`ifdef ADDSUB_WRAP_COUNT_EN
  logic signed [7:0] wrap_cnt;
`endif

  addsub_range_acc #(.MAG_W(MAG_W), .VAL_W(VAL_W), .RANGE(RANGE), .INT_W(INT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mag(mag), .dir(dir), .mode(mode),
    .in_ready(in_ready), .val(val), .val_valid(val_valid),
    .range_hit(range_hit), .int_watch(int_watch)
`ifdef ADDSUB_WRAP_COUNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy counts the edges left until the result appears. While it is
  // nonzero the block is not ready.
  int               m_busy = 0;
  int               m_val = 0;
  int               m_valid = 0;
  int               m_hit = 0;
  logic [INT_W-1:0] m_iw = '0;
  int               m_wc = 0;
  int               p_val, p_hit, p_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_val = 0; m_valid = 0; m_hit = 0; m_iw = '0; m_wc = 0;
    end else begin
      m_valid = 0;
      m_hit   = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_val   = p_val;
          m_valid = 1;
          m_hit   = p_hit;
          m_wc    = m_wc + p_q;
        end
      end else if (en) begin
        int s, q;
        s = dir ? (m_val - int'(mag)) : (m_val + int'(mag));
        m_iw = INT_W'(s);
        if (mode) begin
          p_val  = (s < 0) ? 0 : ((s > RANGE - 1) ? RANGE - 1 : s);
          p_hit  = (p_val != s) ? 1 : 0;
          p_q    = 0;
          m_busy = 1;
        end else begin
          // q = floor(s / RANGE): the signed number of RANGE corrections.
          q      = (s >= 0) ? (s / RANGE) : -((-s + RANGE - 1) / RANGE);
          p_val  = s - q * RANGE;
          p_hit  = (q != 0) ? 1 : 0;
          p_q    = q;
          m_busy = 1 + ((q < 0) ? -q : q);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", int'(in_ready), (m_busy == 0) ? 1 : 0);
      chk("val", int'(val), m_val);
      chk("val_valid", int'(val_valid), m_valid);
      chk("range_hit", int'(range_hit), m_hit);
      chk("int_watch", int'(int_watch), int'(m_iw));
`ifdef ADDSUB_WRAP_COUNT_EN
      if (m_busy == 0) chk("wrap_cnt", int'(wrap_cnt), int'($signed(8'(m_wc))));
`endif
    end
  end

  // ---------------- driver ----------------
  int lat;

  // Issue one command and wait for its completion. With ghost set, extra
  // en pulses are driven while the command is being range-fixed.
  task automatic do_cmd(input int m, input bit d, input bit md, input bit ghost);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) chk("ready_timeout", 0, 1);
    en = 1'b1; mag = MAG_W'(m); dir = d; mode = md;
    @(posedge clk);
    #1 en = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (val_valid) break;
      if (ghost) begin
        en  = (lat >= 2 && lat <= 4);
        mag = MAG_W'($urandom_range(0, 1023));
        dir = 1'($urandom);
      end
    end
    en = 1'b0;
    if (!val_valid) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_val", int'(val), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(val_valid), 0);
    chk("rst_iw", int'(int_watch), 0);

    do_cmd(5, 0, 0, 0);
    chk("c1_val", int'(val), 5);
    chk("c1_lat", lat, 1);
    chk("c1_hit", int'(range_hit), 0);
    chk("c1_iw", int'(int_watch), 5);

    do_cmd(3, 1, 0, 0);
    chk("c2_val", int'(val), 2);

    do_cmd(99, 0, 0, 0);
    chk("c3_iw", int'(int_watch), 101);
    chk("c3_val", int'(val), 1);
    chk("c3_hit", int'(range_hit), 1);
    chk("c3_lat", lat, 2);

    do_cmd(3, 1, 0, 0);
    chk("c4_iw", int'(int_watch), 'hFFE);
    chk("c4_val", int'(val), 98);
    chk("c4_hit", int'(range_hit), 1);

    do_cmd(97, 1, 0, 0);
    chk("c5_val", int'(val), 1);
    do_cmd(3, 1, 1, 0);
    chk("c6_val", int'(val), 0);
    chk("c6_hit", int'(range_hit), 1);
    chk("c6_lat", lat, 1);

    do_cmd(1023, 0, 0, 1);
    chk("c7_val", int'(val), 23);
    chk("c7_lat", lat, 11);
    chk("c7_hit", int'(range_hit), 1);
`ifdef ADDSUB_WRAP_COUNT_EN
    chk("c7_wrap_cnt", int'(wrap_cnt), 10);
`endif

    do_cmd(23, 1, 0, 0);
    do_cmd(1023, 0, 1, 0);
    chk("c8_val", int'(val), 99);
    chk("c8_lat", lat, 1);
    chk("c8_hit", int'(range_hit), 1);

    // Asynchronous reset in the middle of a long wrap reduction.
    do_cmd(99, 1, 0, 0);
    @(negedge clk);
    en = 1'b1; mag = 10'd1023; dir = 1'b0; mode = 1'b0;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_val", int'(val), 0);
    chk("arst_ready", int'(in_ready), 1);
    chk("arst_valid", int'(val_valid), 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    do_cmd(7, 0, 0, 0);
    chk("post_rst_val", int'(val), 7);
    chk("post_rst_iw", int'(int_watch), 7);

    // Randomized single commands, some with ghost en pulses.
    for (int i = 0; i < 200; i++) begin
      do_cmd($urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rand_in_range", (int'(val) < RANGE) ? 1 : 0, 1);
    end

    // Back-to-back: en held high with fresh random commands every cycle.
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      en   = 1'b1;
      mag  = MAG_W'($urandom_range(0, 1023));
      dir  = 1'($urandom);
      mode = 1'($urandom);
      @(negedge clk);
    end
    en = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
